// File: rtl/wide_add_seq.sv
// Multi-cycle N = 32*WORDS bit adder/subtractor: one 32-bit prefix adder slice,
// LSW first, with the carry chained through a register between slices.
module wide_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic              cin,
    input  logic              op_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*WORDS-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    localparam int unsigned N     = 32 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [IDX_W-1:0] idx_q;

    logic [31:0]      slice_x;
    logic [31:0]      slice_y;
    logic [31:0]      slice_sum;
    logic             slice_cout;

    // Kogge-Stone style 32-bit prefix adder; returns {cout, sum}.
    function automatic logic [32:0] prefix_add(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic        c0);
        logic [31:0] p0;
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] gn;
        logic [31:0] pn;
        logic [31:0] c;
        p0 = x ^ y;
        g  = x & y;
        p  = p0;
        for (int s = 1; s < 32; s = s * 2) begin
            gn = g;
            pn = p;
            for (int i = s; i < 32; i++) begin
                gn[i] = g[i] | (p[i] & g[i-s]);
                pn[i] = p[i] & p[i-s];
            end
            g = gn;
            p = pn;
        end
        c = {g[30:0] | (p[30:0] & {31{c0}}), c0};
        return {g[31] | (p[31] & c0), p0 ^ c};
    endfunction

    assign slice_x = a_q[32*idx_q +: 32];
    assign slice_y = b_q[32*idx_q +: 32];
    assign {slice_cout, slice_sum} = prefix_add(slice_x, slice_y, carry_q);

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b ^ {N{op_sub}};
                        carry_q    <= op_sub | cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[32*idx_q +: 32] <= slice_sum;
                    carry_q               <= slice_cout;
                    idx_q                 <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes flags derived from the finished sum.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        cout_q      <= carry_q;
                        ovf_q       <= (a_q[N-1] == b_q[N-1]) & (sum_q[N-1] != a_q[N-1]);
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS=4): directed cases plus random
// operations, expected results queued at accept and compared at out_valid.
module tb_wide_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = 32 * WORDS;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic res_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                   input logic mc, input logic ms);
        res_t         r;
        logic [N:0]   full;
        logic [N-1:0] be;
        be   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + (N+1)'(ms ? 1'b1 : mc);
        r.s  = full[N-1:0];
        r.c  = full[N];
        r.v  = ms ? ((ma[N-1] != mb[N-1]) && (r.s[N-1] != ma[N-1]))
                  : ((ma[N-1] == mb[N-1]) && (r.s[N-1] != ma[N-1]));
        return r;
    endfunction

    function automatic logic [N-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic tc, input logic ts, input res_t exp_r);
        int n;
        n = 0;
        a = ta; b = tb; cin = tc; op_sub = ts; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(exp_r);
        a = rnd128(); b = rnd128(); cin = 1'($urandom); op_sub = 1'($urandom);
    endtask

    task automatic recv(input string nm, input int exp_lat);
        int   lat;
        res_t e;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid_timeout: out_valid=%b, required 1", nm, out_valid);
            return;
        end
        if (exp_lat >= 0) begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required %0d", nm, lat, exp_lat);
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: size=0, required >0", nm);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (sum !== e.s) begin
            errors++;
            $display("FAIL %s sum: got %h, required %h", nm, sum, e.s);
        end
        checks++;
        if (cout !== e.c) begin
            errors++;
            $display("FAIL %s cout: got %b, required %b", nm, cout, e.c);
        end
        checks++;
        if (ovf !== e.v) begin
            errors++;
            $display("FAIL %s ovf: got %b, required %b", nm, ovf, e.v);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_handshake: out_valid=%b in_ready=%b, required 0/1",
                     nm, out_valid, in_ready);
        end
        checks++;
        if (sum !== e.s) begin
            errors++;
            $display("FAIL %s sum_hold: got %h, required %h", nm, sum, e.s);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0",
                     in_ready, out_valid);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b, required 0/0/0", sum, cout, ovf);
        end
    endtask

    task automatic test_add_ripple();
        send({N{1'b1}}, N'(1), 1'b0, 1'b0, '{s: '0, c: 1'b1, v: 1'b0});
        recv("add_ripple", 5);
    endtask

    task automatic test_overflow();
        send({1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 1'b0,
             '{s: {1'b1, {(N-1){1'b0}}}, c: 1'b0, v: 1'b1});
        recv("add_ovf", 5);
    endtask

    task automatic test_sub();
        send(N'(5), N'(7), 1'b0, 1'b1, '{s: {{(N-1){1'b1}}, 1'b0}, c: 1'b0, v: 1'b0});
        recv("sub_borrow", 5);
        send(N'(7), N'(5), 1'b0, 1'b1, '{s: N'(2), c: 1'b1, v: 1'b0});
        recv("sub_noborrow", 5);
    endtask

    task automatic test_carry_in();
        send(N'(32'hFFFF_FFFF), '0, 1'b1, 1'b0, '{s: N'(64'h1_0000_0000), c: 1'b0, v: 1'b0});
        recv("cin_add", 5);
        send(N'(32'hFFFF_FFFF), '0, 1'b1, 1'b1, '{s: N'(32'hFFFF_FFFF), c: 1'b1, v: 1'b0});
        recv("cin_sub_ignored", 5);
    endtask

    task automatic test_back_pressure();
        logic [N-1:0] exp_s;
        exp_s = {1'b0, {(N-1){1'b1}}};
        send({N{1'b1}}, {1'b1, {(N-1){1'b0}}}, 1'b0, 1'b0, '{s: exp_s, c: 1'b1, v: 1'b1});
        repeat (5) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp_s) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b sum=%h, required 1/0/%h",
                         i, out_valid, in_ready, sum, exp_s);
            end
            in_valid = i[0];
            a = rnd128(); b = rnd128();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        recv("backpressure", -1);
        repeat (8) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_ignored_pulses: out_valid=%b in_ready=%b, required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        res_t dummy;
        int   seen;
        send(N'(100), N'(200), 1'b0, 1'b0, '{s: N'(300), c: 1'b0, v: 1'b0});
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: sum=%h cout=%b ovf=%b out_valid=%b, required 0/0/0/0",
                     sum, cout, ovf, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dummy = sb.pop_back();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_result: out_valid cycles=%0d in_ready=%b, required 0/1",
                     seen, in_ready);
        end
        send(N'(3), N'(4), 1'b0, 1'b0, '{s: N'(7), c: 1'b0, v: 1'b0});
        recv("after_abort", 5);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic         rs;
        for (int i = 0; i < 8; i++) begin
            ra = rnd128(); rb = rnd128();
            if (i == 0) rb = ~ra;
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            recv("random", 5);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add_ripple();
        test_overflow();
        test_sub();
        test_carry_in();
        test_back_pressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
